// File: rtl/sparc_fetch_decode_ctrl_pkg.sv
// Shared encodings for the SPARC front end: opcode fields, ALU codes,
// control-vector bit positions and access sizes.
package sparc_fetch_decode_ctrl_pkg;

    localparam int CTRL_W = 19;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_XNOR  = 4'h5,
        ALU_ANDN  = 4'h6,
        ALU_ORN   = 4'h7,
        ALU_SLL   = 4'h8,
        ALU_SRL   = 4'h9,
        ALU_SRA   = 4'hA,
        ALU_PASSB = 4'hB
    } alu_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        SEL_NPC  = 2'b00,
        SEL_TA   = 2'b01,
        SEL_ALU  = 2'b10,
        SEL_HOLD = 2'b11
    } pc_sel_e;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    // arithmetic/logic op3 without the cc bit (op3[4])
    localparam logic [5:0] OP3_ADD  = 6'b000000;
    localparam logic [5:0] OP3_AND  = 6'b000001;
    localparam logic [5:0] OP3_OR   = 6'b000010;
    localparam logic [5:0] OP3_XOR  = 6'b000011;
    localparam logic [5:0] OP3_SUB  = 6'b000100;
    localparam logic [5:0] OP3_ANDN = 6'b000101;
    localparam logic [5:0] OP3_ORN  = 6'b000110;
    localparam logic [5:0] OP3_XNOR = 6'b000111;
    localparam logic [5:0] OP3_SLL  = 6'b100101;
    localparam logic [5:0] OP3_SRL  = 6'b100110;
    localparam logic [5:0] OP3_SRA  = 6'b100111;
    localparam logic [5:0] OP3_JMPL = 6'b111000;

    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_LDSB = 6'b001001;
    localparam logic [5:0] OP3_LDSH = 6'b001010;
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;

    localparam int SIG_CALL    = 0;
    localparam int SIG_JMPL    = 1;
    localparam int SIG_LOAD    = 2;
    localparam int SIG_RFEN    = 3;
    localparam int SIG_SE      = 4;
    localparam int SIG_RW      = 5;
    localparam int SIG_MEMEN   = 6;
    localparam int SIG_SIZE_LO = 7;
    localparam int SIG_CCEN    = 9;
    localparam int SIG_I31     = 10;
    localparam int SIG_I30     = 11;
    localparam int SIG_I24     = 12;
    localparam int SIG_I13     = 13;
    localparam int SIG_ALU_LO  = 14;
    localparam int SIG_BRANCH  = 18;

endpackage

// File: rtl/sparc_fetch_decode_ctrl_if.sv
// Fetch/decode bus: pipeline-side controls in, PC and decoded controls out.
interface sparc_fetch_decode_ctrl_if;
    import sparc_fetch_decode_ctrl_pkg::*;

    logic              LE;
    logic [1:0]        mux_select;
    logic [31:0]       TA;
    logic [31:0]       ALU_OUT;
    logic [31:0]       instr;
    logic [31:0]       PC;
    logic [31:0]       nPC;
    logic [CTRL_W-1:0] instr_signals;

    modport master (
        output LE, mux_select, TA, ALU_OUT, instr,
        input  PC, nPC, instr_signals
    );

    modport slave (
        input  LE, mux_select, TA, ALU_OUT, instr,
        output PC, nPC, instr_signals
    );

endinterface

// File: rtl/sparc_fetch_decode_ctrl_control_decoder.sv
// Combinational instruction decoder producing the 19-bit control vector.
module sparc_fetch_decode_ctrl_control_decoder
    import sparc_fetch_decode_ctrl_pkg::*;
(
    input  logic [31:0]       i_instr,
    output logic [CTRL_W-1:0] o_sig
);
    logic [1:0] w_op;
    logic [2:0] w_op2;
    logic [5:0] w_op3;
    logic [5:0] w_op3_base;
    logic       w_unused_bits;

    assign w_op       = i_instr[31:30];
    assign w_op2      = i_instr[24:22];
    assign w_op3      = i_instr[24:19];
    assign w_op3_base = {w_op3[5], 1'b0, w_op3[3:0]};
    assign w_unused_bits = ^{i_instr[29:25], i_instr[18:14], i_instr[12:0]};

    alu_op_e w_alu;
    logic    w_arith_hit;

    always_comb begin
        o_sig       = '0;
        w_alu       = ALU_ADD;
        w_arith_hit = 1'b0;
        case (w_op)
            OP_CALL: begin
                o_sig[SIG_CALL] = 1'b1;
                o_sig[SIG_RFEN] = 1'b1;
            end
            OP_FMT2: begin
                if (w_op2 == OP2_BICC) begin
                    o_sig[SIG_BRANCH] = 1'b1;
                end else if (w_op2 == OP2_SETHI) begin
                    o_sig[SIG_RFEN] = 1'b1;
                    w_alu           = ALU_PASSB;
                end
            end
            OP_ARITH: begin
                // op3[4] selects the cc-setting twin of the logic/arith ops
                w_arith_hit = 1'b1;
                case (w_op3_base)
                    OP3_ADD:  w_alu = ALU_ADD;
                    OP3_SUB:  w_alu = ALU_SUB;
                    OP3_AND:  w_alu = ALU_AND;
                    OP3_OR:   w_alu = ALU_OR;
                    OP3_XOR:  w_alu = ALU_XOR;
                    OP3_ANDN: w_alu = ALU_ANDN;
                    OP3_ORN:  w_alu = ALU_ORN;
                    OP3_XNOR: w_alu = ALU_XNOR;
                    default:  w_arith_hit = 1'b0;
                endcase
                o_sig[SIG_RFEN] = w_arith_hit;
                o_sig[SIG_CCEN] = w_arith_hit & w_op3[4];
                case (w_op3)
                    OP3_SLL:  begin o_sig[SIG_RFEN] = 1'b1; w_alu = ALU_SLL; end
                    OP3_SRL:  begin o_sig[SIG_RFEN] = 1'b1; w_alu = ALU_SRL; end
                    OP3_SRA:  begin o_sig[SIG_RFEN] = 1'b1; w_alu = ALU_SRA; end
                    OP3_JMPL: begin o_sig[SIG_RFEN] = 1'b1; o_sig[SIG_JMPL] = 1'b1; end
                    default:  ;
                endcase
            end
            default: begin
                case (w_op3)
                    OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDSB, OP3_LDSH: begin
                        o_sig[SIG_LOAD]  = 1'b1;
                        o_sig[SIG_RFEN]  = 1'b1;
                        o_sig[SIG_MEMEN] = 1'b1;
                    end
                    OP3_ST, OP3_STB, OP3_STH: begin
                        o_sig[SIG_MEMEN] = 1'b1;
                        o_sig[SIG_RW]    = 1'b1;
                    end
                    default: ;
                endcase
                case (w_op3)
                    OP3_LD, OP3_ST:     o_sig[SIG_SIZE_LO +: 2] = SZ_WORD;
                    OP3_LDUH, OP3_STH:  o_sig[SIG_SIZE_LO +: 2] = SZ_HALF;
                    OP3_LDSH: begin
                        o_sig[SIG_SIZE_LO +: 2] = SZ_HALF;
                        o_sig[SIG_SE]           = 1'b1;
                    end
                    OP3_LDSB:           o_sig[SIG_SE] = 1'b1;
                    default:            o_sig[SIG_SIZE_LO +: 2] = SZ_BYTE;
                endcase
            end
        endcase
        o_sig[SIG_ALU_LO +: 4] = w_alu;
        o_sig[SIG_I31] = i_instr[31];
        o_sig[SIG_I30] = i_instr[30];
        o_sig[SIG_I24] = i_instr[24];
        o_sig[SIG_I13] = i_instr[13];
    end
endmodule

// File: rtl/sparc_fetch_decode_ctrl_pc_adder.sv
// Sequential next-PC adder; wraps modulo 2^32, carry discarded.
module sparc_fetch_decode_ctrl_pc_adder #(
    parameter logic [31:0] PC_INC = 32'd4
) (
    input  logic [31:0] i_pc,
    output logic [31:0] o_npc
);
    assign o_npc = i_pc + PC_INC;
endmodule

// File: rtl/sparc_fetch_decode_ctrl.sv
// Front-end control: PC register with next-PC select, sequential adder,
// and the ID-stage control decoder.
module sparc_fetch_decode_ctrl
    import sparc_fetch_decode_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input logic                     clk,
    input logic                     clr,
    sparc_fetch_decode_ctrl_if.slave bus
);
    logic [31:0]       r_pc;
    logic [31:0]       w_npc;
    logic [CTRL_W-1:0] w_dec;

    sparc_fetch_decode_ctrl_pc_adder #(.PC_INC(PC_INC)) u_pc_adder (
        .i_pc  (r_pc),
        .o_npc (w_npc)
    );

    sparc_fetch_decode_ctrl_control_decoder u_control_decoder (
        .i_instr (bus.instr),
        .o_sig   (w_dec)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pc <= RESET_PC;
        end else if (bus.LE) begin
            case (pc_sel_e'(bus.mux_select))
                SEL_NPC: r_pc <= w_npc;
                SEL_TA:  r_pc <= bus.TA;
                SEL_ALU: r_pc <= bus.ALU_OUT;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign bus.PC            = r_pc;
    assign bus.nPC           = w_npc;
    assign bus.instr_signals = clr ? w_dec : '0;
endmodule

// File: tb/tb_sparc_fetch_decode_ctrl.sv
// Self-checking bench: directed PC/decoder scenarios plus randomized runs
// compared against an instruction-table reference model.
module tb_sparc_fetch_decode_ctrl;
    logic clk;
    logic clr;
    int   checks;
    int   errors;
    logic [31:0] m_pc;

    sparc_fetch_decode_ctrl_if bus();

    sparc_fetch_decode_ctrl #(.RESET_PC(32'h0), .PC_INC(32'd4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic le,
                                                  input logic [1:0] sel, input logic [31:0] ta,
                                                  input logic [31:0] alu);
        if (!le) return pc;
        case (sel)
            2'd0:    return pc + 32'd4;
            2'd1:    return ta;
            2'd2:    return alu;
            default: return pc;
        endcase
    endfunction

    // Table of full control words (raw bits excluded) keyed by {op, op3}.
    function automatic logic [18:0] model_decode(input logic [31:0] ins);
        logic [18:0] c;
        logic [7:0]  key;
        c   = 19'h0;
        key = {ins[31:30], ins[24:19]};
        if (ins[31:30] == 2'b01) c = 19'h00009;
        else if (ins[31:30] == 2'b00) begin
            if (ins[24:22] == 3'b010)      c = 19'h40000;
            else if (ins[24:22] == 3'b100) c = 19'h2C008;
        end else begin
            case (key)
                8'b10_000000: c = 19'h00008;
                8'b10_000100: c = 19'h04008;
                8'b10_000001: c = 19'h08008;
                8'b10_000010: c = 19'h0C008;
                8'b10_000011: c = 19'h10008;
                8'b10_000101: c = 19'h18008;
                8'b10_000110: c = 19'h1C008;
                8'b10_000111: c = 19'h14008;
                8'b10_010000: c = 19'h00208;
                8'b10_010100: c = 19'h04208;
                8'b10_010001: c = 19'h08208;
                8'b10_010010: c = 19'h0C208;
                8'b10_010011: c = 19'h10208;
                8'b10_010101: c = 19'h18208;
                8'b10_010110: c = 19'h1C208;
                8'b10_010111: c = 19'h14208;
                8'b10_100101: c = 19'h20008;
                8'b10_100110: c = 19'h24008;
                8'b10_100111: c = 19'h28008;
                8'b10_111000: c = 19'h0000A;
                8'b11_000000: c = 19'h0014C;
                8'b11_000001: c = 19'h0004C;
                8'b11_000010: c = 19'h000CC;
                8'b11_001001: c = 19'h0005C;
                8'b11_001010: c = 19'h000DC;
                8'b11_000100: c = 19'h00160;
                8'b11_000101: c = 19'h00060;
                8'b11_000110: c = 19'h000E0;
                default:      c = 19'h0;
            endcase
        end
        c = c | ({18'h0, ins[13]} << 13) | ({18'h0, ins[24]} << 12)
              | ({18'h0, ins[30]} << 11) | ({18'h0, ins[31]} << 10);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic le, input logic [1:0] sel,
                         input logic [31:0] ta, input logic [31:0] alu);
        bus.LE = le; bus.mux_select = sel; bus.TA = ta; bus.ALU_OUT = alu;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        drive(1'b1, 2'b00, 32'h0, 32'h0);
        bus.instr = 32'h8600_4002;
        #2;
        checks++;
        if (bus.PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 32'h0); end
        checks++;
        if (bus.nPC !== 32'h4) begin errors++; $display("FAIL reset_npc: got %h expected %h", bus.nPC, 32'h4); end
        checks++;
        if (bus.instr_signals !== 19'h0) begin errors++; $display("FAIL reset_sig: got %h expected %h", bus.instr_signals, 19'h0); end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.PC !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, bus.PC, 32'(4 * i)); end
        end
    endtask

    task automatic test_select();
        drive(1'b1, 2'b01, 32'h8, 32'h0); tick();
        drive(1'b1, 2'b01, 32'h40, 32'h0); tick();
        checks++;
        if (bus.PC !== 32'h40) begin errors++; $display("FAIL sel_ta: got %h expected %h", bus.PC, 32'h40); end
        drive(1'b1, 2'b10, 32'h0, 32'h100); tick();
        checks++;
        if (bus.PC !== 32'h100) begin errors++; $display("FAIL sel_alu: got %h expected %h", bus.PC, 32'h100); end
        drive(1'b1, 2'b11, 32'h55, 32'h77); tick();
        checks++;
        if (bus.PC !== 32'h100) begin errors++; $display("FAIL sel_hold: got %h expected %h", bus.PC, 32'h100); end
        drive(1'b0, 2'b00, 32'h55, 32'h77); tick();
        checks++;
        if (bus.PC !== 32'h100) begin errors++; $display("FAIL le_hold: got %h expected %h", bus.PC, 32'h100); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0); tick();
        checks++;
        if (bus.nPC !== 32'h0) begin errors++; $display("FAIL wrap_npc: got %h expected %h", bus.nPC, 32'h0); end
        drive(1'b1, 2'b00, 32'h0, 32'h0); tick();
        checks++;
        if (bus.PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", bus.PC, 32'h0); end
    endtask

    task automatic test_decode_directed();
        logic [31:0] ins [4] = '{32'h8600_4002, 32'h4000_0010, 32'hC400_6004, 32'h1080_0004};
        logic [18:0] exp [4] = '{19'h00408, 19'h00809, 19'h02D4C, 19'h40000};
        for (int i = 0; i < 4; i++) begin
            bus.instr = ins[i];
            #1;
            checks++;
            if (bus.instr_signals !== exp[i]) begin
                errors++;
                $display("FAIL decode_%h: got %h expected %h", ins[i], bus.instr_signals, exp[i]);
            end
        end
    endtask

    task automatic test_decode_random();
        logic [7:0]  keys [12] = '{8'b10_000000, 8'b10_010100, 8'b10_000111, 8'b10_100110,
                                   8'b10_111000, 8'b11_000000, 8'b11_000010, 8'b11_001001,
                                   8'b11_001010, 8'b11_000101, 8'b11_000110, 8'b10_001000};
        logic [31:0] ins;
        logic [7:0]  k;
        logic [18:0] exp;
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                k = keys[$urandom_range(0, 11)];
                ins[31:30] = k[7:6];
                ins[24:19] = k[5:0];
            end
            bus.instr = ins;
            #1;
            exp = model_decode(ins);
            checks++;
            if (bus.instr_signals !== exp) begin
                errors++;
                $display("FAIL decode_rand %h: got %h expected %h", ins, bus.instr_signals, exp);
            end
        end
    endtask

    task automatic test_pc_random();
        logic        le;
        logic [1:0]  sel;
        logic [31:0] ta, alu;
        m_pc = bus.PC;
        for (int i = 0; i < 200; i++) begin
            le  = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3));
            ta  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            alu = $urandom;
            drive(le, sel, ta, alu);
            m_pc = model_next_pc(m_pc, le, sel, ta, alu);
            tick();
            checks++;
            if (bus.PC !== m_pc || bus.nPC !== m_pc + 32'd4) begin
                errors++;
                $display("FAIL pc_rand%0d: got %h/%h expected %h/%h", i, bus.PC, bus.nPC, m_pc, m_pc + 32'd4);
            end
        end
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 2'b01, 32'h1234, 32'h0); tick();
        bus.instr = 32'hC400_6004;
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if (bus.PC !== 32'h0) begin errors++; $display("FAIL midrun_pc: got %h expected %h", bus.PC, 32'h0); end
        checks++;
        if (bus.instr_signals !== 19'h0) begin errors++; $display("FAIL midrun_sig: got %h expected %h", bus.instr_signals, 19'h0); end
        tick();
        checks++;
        if (bus.PC !== 32'h0) begin errors++; $display("FAIL midrun_hold: got %h expected %h", bus.PC, 32'h0); end
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++;
        if (bus.instr_signals !== 19'h02D4C) begin errors++; $display("FAIL midrun_dec: got %h expected %h", bus.instr_signals, 19'h02D4C); end
        drive(1'b1, 2'b00, 32'h0, 32'h0); tick();
        checks++;
        if (bus.PC !== 32'h4) begin errors++; $display("FAIL midrun_resume: got %h expected %h", bus.PC, 32'h4); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_select();
        test_wrap();
        test_decode_directed();
        test_decode_random();
        test_pc_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
